// File: rtl/noc_pkg.sv
// Shared types and constants for the NoC output-port arbiter and related
// router blocks (flit layout, arbiter FSM encoding).
package noc_pkg;

   localparam int FLIT_W   = 16;
   localparam int HEAD_BIT = 15;
   localparam int TAIL_BIT = 14;

   typedef logic [FLIT_W-1:0] flit_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      CAPTURE = 2'd2
   } arb_state_t;

   // True when the flit closes a packet (also true for a head+tail flit).
   function automatic logic is_tail(input flit_t f);
      return f[TAIL_BIT];
   endfunction

endpackage

// File: rtl/noc_output_arbiter_rr_picker.sv
// rr_picker: combinational round-robin selector. Searches the request vector
// starting at ptr and wrapping modulo N; returns a one-hot grant and a found
// flag. Shared with the VC allocator, so it carries no arbiter-specific state.
module rr_picker
   import noc_pkg::*;
#(
   parameter int N     = 5,
   parameter int PTR_W = 3
) (
   input  logic [N-1:0]     req,
   input  logic [PTR_W-1:0] ptr,
   output logic [N-1:0]     grant,
   output logic             found
);

   // First requester at or after ptr (circularly) wins.
   always_comb begin
      grant = '0;
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
         int   idx;
         logic hit_s;
         idx        = (int'(ptr) + k) % N;
         hit_s      = req[idx] & ~found;
         grant[idx] = grant[idx] | hit_s;
         found      = found | hit_s;
      end
   end

endmodule

// File: rtl/noc_output_arbiter.sv
// noc_output_arbiter: wormhole output-port arbiter. Picks an input buffer
// round-robin, drains it one flit per two cycles (read, then capture) under
// downstream credit flow control, and holds the grant from head to tail.
// Optional build macro ARB_FLIT_CNT_EN adds a 32-bit forwarded-flit counter
// on port flit_cnt_o.
module noc_output_arbiter
   import noc_pkg::*;
#(
   parameter int NUM_IN  = 5,
   parameter int FLIT_W  = 16,
   parameter int CREDITS = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_IN-1:0]        in_empty_i,
   input  logic [NUM_IN-1:0]        in_valid_i,
   input  logic [NUM_IN*FLIT_W-1:0] in_data_i,
   output logic [NUM_IN-1:0]        in_read_o,
   output logic                     out_valid_o,
   output logic [FLIT_W-1:0]        out_data_o,
   input  logic                     out_credit_i,
   output logic [NUM_IN-1:0]        grant_o,
   output logic                     busy_o
`ifdef ARB_FLIT_CNT_EN
   ,output logic [31:0]             flit_cnt_o
`endif
);

   localparam int PTR_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
   localparam int CNT_W = $clog2(CREDITS + 1);
   localparam logic [CNT_W-1:0] CRED_MAX  = CNT_W'(CREDITS);
   localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(NUM_IN - 1);

   arb_state_t              state_r;
   arb_state_t              state_nxt_s;
   logic [NUM_IN-1:0]       grant_r;
   logic [PTR_W-1:0]        rr_ptr_r;
   logic [CNT_W-1:0]        credits_r;
   logic                    out_valid_r;
   logic [FLIT_W-1:0]       out_data_r;

   logic [NUM_IN-1:0]       req_s;
   logic [NUM_IN-1:0]       pick_s;
   logic                    found_s;
   logic [PTR_W-1:0]        g_idx_s;
   logic [PTR_W-1:0]        nxt_ptr_s;
   logic [FLIT_W-1:0]       cap_flit_s;
   logic                    issue_s;
   logic                    capture_s;
   logic                    tail_s;

   assign req_s = ~in_empty_i;

   rr_picker #(
      .N     (NUM_IN),
      .PTR_W (PTR_W)
   ) u_picker (
      .req   (req_s),
      .ptr   (rr_ptr_r),
      .grant (pick_s),
      .found (found_s)
   );

   // Binary index of the current owner (grant is one-hot or zero).
   always_comb begin
      g_idx_s = '0;
      for (int i = 0; i < NUM_IN; i++) begin
         g_idx_s = g_idx_s | (grant_r[i] ? PTR_W'(i) : PTR_W'(0));
      end
   end

   // Per-cycle qualifiers: read issue, flit capture, tail detect, next pointer.
   always_comb begin
      cap_flit_s = in_data_i[int'(g_idx_s)*FLIT_W +: FLIT_W];
      issue_s    = (state_r == ISSUE) && !in_empty_i[g_idx_s] && (credits_r != '0);
      capture_s  = (state_r == CAPTURE) && in_valid_i[g_idx_s];
      tail_s     = cap_flit_s[TAIL_BIT];
      if (g_idx_s == LAST_IDX) begin
         nxt_ptr_s = '0;
      end else begin
         nxt_ptr_s = g_idx_s + PTR_W'(1);
      end
   end

   // Read strobe goes only to the owner, only in the cycle a read is issued.
   always_comb begin
      in_read_o = '0;
      if (issue_s) begin
         in_read_o = grant_r;
      end else begin
         in_read_o = '0;
      end
   end

   // Next-state logic: one read then one capture per flit until the tail.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (found_s) begin
               state_nxt_s = ISSUE;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         ISSUE: begin
            if (issue_s) begin
               state_nxt_s = CAPTURE;
            end else begin
               state_nxt_s = ISSUE;
            end
         end
         CAPTURE: begin
            if (capture_s) begin
               state_nxt_s = tail_s ? IDLE : ISSUE;
            end else begin
               state_nxt_s = CAPTURE;
            end
         end
         default: state_nxt_s = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Grant lock and round-robin pointer: set on pick, released after the tail.
   always_ff @(posedge clk) begin
      if (reset) begin
         grant_r  <= '0;
         rr_ptr_r <= '0;
      end else if ((state_r == IDLE) && found_s) begin
         grant_r  <= pick_s;
      end else if (capture_s && tail_s) begin
         grant_r  <= '0;
         rr_ptr_r <= nxt_ptr_s;
      end
   end

   // Downstream credit counter: debit per read, credit per return pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         credits_r <= CRED_MAX;
      end else begin
         case ({issue_s, out_credit_i})
            2'b10:   credits_r <= credits_r - CNT_W'(1);
            2'b01:   credits_r <= (credits_r == CRED_MAX) ? credits_r : credits_r + CNT_W'(1);
            default: credits_r <= credits_r;
         endcase
      end
   end

   // Output flit register: one-cycle valid pulse per captured flit.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid_r <= 1'b0;
         out_data_r  <= '0;
      end else begin
         out_valid_r <= capture_s;
         if (capture_s) begin
            out_data_r <= cap_flit_s;
         end
      end
   end

`ifdef ARB_FLIT_CNT_EN
   logic [31:0] flit_cnt_r;

   // Forwarded-flit counter; wraps naturally at 2^32.
   always_ff @(posedge clk) begin
      if (reset) begin
         flit_cnt_r <= 32'd0;
      end else if (capture_s) begin
         flit_cnt_r <= flit_cnt_r + 32'd1;
      end
   end

   assign flit_cnt_o = flit_cnt_r;
`endif

   assign out_valid_o = out_valid_r;
   assign out_data_o  = out_data_r;
   assign grant_o     = grant_r;
   assign busy_o      = (state_r != IDLE);

endmodule

// File: tb/tb_noc_output_arbiter.sv
// Directed testbench for noc_output_arbiter: a simple FIFO model per input,
// a sampling monitor that logs read strobes and output flits, and a linear
// sequence of directed steps checked with immediate assertions.
module tb_noc_output_arbiter;
   import noc_pkg::*;

   localparam int NI = 5;
   localparam int FW = 16;

   logic          clk = 1'b0;
   logic          reset;
   logic [NI-1:0] in_empty;
   logic [NI-1:0] in_valid = '0;
   logic [NI*FW-1:0] in_data = '0;
   logic [NI-1:0] in_read;
   logic          out_valid;
   logic [FW-1:0] out_data;
   logic          out_credit;
   logic [NI-1:0] grant;
   logic          busy;
`ifdef ARB_FLIT_CNT_EN
   logic [31:0]   flit_cnt;
`endif

   noc_output_arbiter #(.NUM_IN(NI), .FLIT_W(FW), .CREDITS(8)) dut (
      .clk          (clk),
      .reset        (reset),
      .in_empty_i   (in_empty),
      .in_valid_i   (in_valid),
      .in_data_i    (in_data),
      .in_read_o    (in_read),
      .out_valid_o  (out_valid),
      .out_data_o   (out_data),
      .out_credit_i (out_credit),
      .grant_o      (grant),
`ifdef ARB_FLIT_CNT_EN
      .flit_cnt_o   (flit_cnt),
`endif
      .busy_o       (busy)
   );

   always #5 clk = ~clk;

   // ---------------- input buffer model ----------------
   logic [15:0] mem [NI][256];
   logic [7:0]  wr_ptr [NI] = '{default: 8'd0};
   logic [7:0]  rd_ptr [NI] = '{default: 8'd0};

   for (genvar gi = 0; gi < NI; gi++) begin : g_empty
      assign in_empty[gi] = (wr_ptr[gi] == rd_ptr[gi]);
   end

   // Buffer read: data and valid appear the cycle after the strobe.
   always @(posedge clk) begin
      for (int i = 0; i < NI; i++) begin
         if (in_read[i] && (wr_ptr[i] != rd_ptr[i])) begin
            in_data[i*FW +: FW] <= mem[i][rd_ptr[i]];
            in_valid[i]         <= 1'b1;
            rd_ptr[i]           <= rd_ptr[i] + 8'd1;
         end else begin
            in_valid[i] <= 1'b0;
         end
      end
   end

   task automatic push(input int b, input logic [15:0] f);
      mem[b][wr_ptr[b]] = f;
      wr_ptr[b] = wr_ptr[b] + 8'd1;
   endtask

   // ---------------- monitor ----------------
   int          cyc = 0;
   logic [15:0] out_log [512];
   int          out_cyc [512];
   int          rd_idx  [512];
   int          rd_cyc  [512];
   int          n_out = 0;
   int          n_rd  = 0;
   int          viol  = 0;

   // Cycle stamp.
   always @(posedge clk) cyc <= cyc + 1;

   // Log read strobes and output flits mid low phase, after input drives.
   always @(negedge clk) begin
      #2;
      if (in_read != '0 && n_rd < 512) begin
         rd_idx[n_rd] = 0;
         for (int i = 0; i < NI; i++) if (in_read[i]) rd_idx[n_rd] = i;
         rd_cyc[n_rd] = cyc;
         n_rd++;
         if ($countones(in_read) != 1 || (in_read & ~grant) != '0) viol++;
      end
      if (out_valid && n_out < 512) begin
         out_log[n_out] = out_data;
         out_cyc[n_out] = cyc;
         n_out++;
      end
   end

   // ---------------- checking ----------------
   int n_chk  = 0;
   int n_pass = 0;
   int n_fail = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      out_credit = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic wait_idle(input int budget, input logic auto_cr, output logic ok);
      ok = 1'b0;
      for (int k = 0; k < budget; k++) begin
         @(negedge clk);
         out_credit = auto_cr & out_valid;
         if (!busy && (&in_empty) && !out_valid) begin
            ok = 1'b1;
            break;
         end
      end
      out_credit = 1'b0;
   endtask

   // Global time bound.
   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not reach the end");
      $fatal(1);
   end

   initial begin
      logic ok;
      int   bo, br, cnt4, rc4;

      reset      = 1'b1;
      out_credit = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_grant",   32'(grant), 32'h0);
      check("rst_busy",    32'(busy), 32'h0);
      check("rst_ovalid",  32'(out_valid), 32'h0);
      check("rst_odata",   32'(out_data), 32'h0);
      check("rst_read",    32'(in_read), 32'h0);
      check("rst_credits", 32'(dut.credits_r), 32'd8);
      check("rst_rrptr",   32'(dut.rr_ptr_r), 32'd0);
      reset = 1'b0;

      // Credit return at full is ignored.
      @(negedge clk);
      out_credit = 1'b1;
      @(negedge clk);
      out_credit = 1'b0;
      check("cred_saturate", 32'(dut.credits_r), 32'd8);

      // ---- 3-flit packet from buffer 2 ----
      push(2, 16'h8000); push(2, 16'h0001); push(2, 16'h4002);
      bo = n_out; br = n_rd;
      @(negedge clk);
      check("t1_grant", 32'(grant), 32'h04);
      check("t1_read_latency", 32'(in_read), 32'h04);
      wait_idle(60, 1'b0, ok);
      check("t1_done", 32'(ok), 32'd1);
      check("t1_nout", 32'(n_out - bo), 32'd3);
      check("t1_f0", 32'(out_log[bo]),   32'h8000);
      check("t1_f1", 32'(out_log[bo+1]), 32'h0001);
      check("t1_f2", 32'(out_log[bo+2]), 32'h4002);
      for (int k = 0; k < 3; k++)
         check($sformatf("t1_lat%0d", k), 32'(out_cyc[bo+k] - rd_cyc[br+k]), 32'd2);
      check("t1_rrptr",   32'(dut.rr_ptr_r), 32'd3);
      check("t1_credits", 32'(dut.credits_r), 32'd5);
      check("t1_idle",    32'(busy), 32'h0);

      // ---- round robin from rr_ptr=0 ----
      do_reset();
      push(0, 16'hC0AA); push(3, 16'hC0BB);
      bo = n_out;
      wait_idle(60, 1'b0, ok);
      check("t2a_done", 32'(ok), 32'd1);
      check("t2a_nout", 32'(n_out - bo), 32'd2);
      check("t2a_first",  32'(out_log[bo]),   32'hC0AA);
      check("t2a_second", 32'(out_log[bo+1]), 32'hC0BB);
      check("t2a_rrptr",  32'(dut.rr_ptr_r), 32'd4);

      // ---- round robin from rr_ptr=1 ----
      do_reset();
      push(0, 16'hC0A0);
      wait_idle(60, 1'b0, ok);
      check("t2b_rrptr1", 32'(dut.rr_ptr_r), 32'd1);
      push(0, 16'hC0AA); push(3, 16'hC0BB);
      bo = n_out;
      wait_idle(60, 1'b0, ok);
      check("t2b_done", 32'(ok), 32'd1);
      check("t2b_first",  32'(out_log[bo]),   32'hC0BB);
      check("t2b_second", 32'(out_log[bo+1]), 32'hC0AA);
      check("t2b_rrptr",  32'(dut.rr_ptr_r), 32'd1);

      // ---- lock: buffer 1 mid-packet, buffer 4 requesting ----
      do_reset();
      push(1, 16'h8011);
      bo = n_out; br = n_rd;
      repeat (6) @(negedge clk);
      push(4, 16'hC044);
      repeat (10) @(negedge clk);
      cnt4 = 0;
      for (int k = br; k < n_rd; k++) if (rd_idx[k] == 4) cnt4++;
      check("t3_lock_grant", 32'(grant), 32'h02);
      check("t3_no_read4", 32'(cnt4), 32'd0);
      check("t3_busy", 32'(busy), 32'h1);
      push(1, 16'h4012);
      wait_idle(80, 1'b0, ok);
      check("t3_done", 32'(ok), 32'd1);
      check("t3_f0", 32'(out_log[bo]),   32'h8011);
      check("t3_f1", 32'(out_log[bo+1]), 32'h4012);
      check("t3_f2", 32'(out_log[bo+2]), 32'hC044);
      rc4 = -1;
      for (int k = n_rd - 1; k >= br; k--) if (rd_idx[k] == 4) rc4 = rd_cyc[k];
      check("t3_read4_after_tail", 32'(rc4 > out_cyc[bo+1]), 32'd1);

      // ---- credit starvation with a 9-flit packet ----
      do_reset();
      push(0, 16'h8100);
      for (int k = 1; k < 8; k++) push(0, 16'h0100 + 16'(k));
      push(0, 16'h4108);
      bo = n_out; br = n_rd;
      repeat (40) @(negedge clk);
      check("t4_reads8",   32'(n_rd - br), 32'd8);
      check("t4_outs8",    32'(n_out - bo), 32'd8);
      check("t4_credits0", 32'(dut.credits_r), 32'd0);
      check("t4_stall_state", 32'(dut.state_r), 32'(ISSUE));
      check("t4_no_read", 32'(in_read), 32'h0);
      out_credit = 1'b1;
      @(negedge clk);
      out_credit = 1'b0;
      wait_idle(40, 1'b0, ok);
      check("t4_done",    32'(ok), 32'd1);
      check("t4_reads9",  32'(n_rd - br), 32'd9);
      check("t4_tail",    32'(out_log[n_out-1]), 32'h4108);
      check("t4_credits_end", 32'(dut.credits_r), 32'd0);

      // ---- credit return in the same cycle as a read ----
      do_reset();
      push(0, 16'hC0CC);
      @(negedge clk);
      check("t4b_read", 32'(in_read), 32'h01);
      out_credit = 1'b1;
      @(negedge clk);
      out_credit = 1'b0;
      check("t4b_same_cycle", 32'(dut.credits_r), 32'd8);
      wait_idle(40, 1'b0, ok);
      check("t4b_done", 32'(ok), 32'd1);

      // ---- reset while in CAPTURE ----
      do_reset();
      push(2, 16'h8022); push(2, 16'h4023);
      @(negedge clk);
      @(negedge clk);
      check("t5_in_capture", 32'(dut.state_r), 32'(CAPTURE));
      reset = 1'b1;
      @(negedge clk);
      check("t5_grant",   32'(grant), 32'h0);
      check("t5_busy",    32'(busy), 32'h0);
      check("t5_ovalid",  32'(out_valid), 32'h0);
      check("t5_credits", 32'(dut.credits_r), 32'd8);
      check("t5_read",    32'(in_read), 32'h0);
      reset = 1'b0;
      wait_idle(60, 1'b0, ok);
      check("t5_done", 32'(ok), 32'd1);
      check("t5_resume", 32'(out_log[n_out-1]), 32'h4023);

`ifdef ARB_FLIT_CNT_EN
      // ---- flit counter: 3 packets x 4 flits ----
      do_reset();
      for (int b = 0; b < 3; b++) begin
         push(b, 16'h8000 + 16'(b));
         push(b, 16'h0010 + 16'(b));
         push(b, 16'h0020 + 16'(b));
         push(b, 16'h4030 + 16'(b));
      end
      wait_idle(300, 1'b1, ok);
      check("t6_done", 32'(ok), 32'd1);
      check("t6_flit_cnt", flit_cnt, 32'd12);
`endif

      check("onehot_grant_only", 32'(viol), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/noc_output_arbiter.md
Name: noc_output_arbiter

Overview:
Wormhole output-port arbiter for one router output. Shares the port among NUM_IN input buffers (N/S/E/W/local), which deliver 16-bit flits. Selects a requester round-robin, drains it flit by flit through the buffers' read strobe, forwards flits downstream under credit flow control, and holds the grant from head flit to tail flit. One arbiter instance per router output port.

Parameters:
NUM_IN, 5, number of requesting input buffers.
FLIT_W, 16, flit width; bit 15 = head, bit 14 = tail.
CREDITS, 8, downstream buffer depth; reset value of the credit counter.

Ports:
clk  in  1  clock; all logic on the rising edge.
reset  in  1  synchronous, active-high reset.
in_empty_i  in  NUM_IN  per-buffer empty flag.
in_valid_i  in  NUM_IN  per-buffer read-data valid; asserted the cycle after that buffer's read strobe.
in_data_i  in  NUM_IN*FLIT_W  per-buffer read data; slice i is bits [i*FLIT_W +: FLIT_W].
in_read_o  out  NUM_IN  one-hot read strobe to the buffers.
out_valid_o  out  1  registered flit-valid to the downstream link.
out_data_o  out  FLIT_W  registered flit to the downstream link.
out_credit_i  in  1  one pulse returns one downstream slot.
grant_o  out  NUM_IN  one-hot current owner; zero when idle.
busy_o  out  1  high whenever state is not IDLE.

Behaviour:
- Reset values: state IDLE; grant_o=0; rr_ptr=0; credits=CREDITS; in_read_o=0; out_valid_o=0; out_data_o=0; busy_o=0.
- FSM states:
  - IDLE: requesters are all i with in_empty_i[i]=0. If any requester exists, pick the first index searching rr_ptr, rr_ptr+1, ... modulo NUM_IN. Register the pick into grant_o and go to ISSUE. No read is issued in IDLE.
  - ISSUE: if in_empty_i[g]=0 and credits>0:
    - in_read_o[g]=1 combinationally this cycle;
    - credits decrement;
    - next state CAPTURE.
    Otherwise stay in ISSUE with the grant held (mid-packet stall, including credit starvation).
  - CAPTURE: on in_valid_i[g]=1:
    - next cycle out_valid_o=1 and out_data_o=in_data_i slice g;
    - if flit bit 14 (tail) is set: rr_ptr=(g+1) mod NUM_IN, grant_o=0, next state IDLE;
    - else next state ISSUE.
    If in_valid_i[g]=0, remain in CAPTURE.
- Throughput: at most one read every two cycles per port. This is deliberate: it guarantees no read past a tail flit.
- Latency: read strobe to out_valid_o is 2 cycles. Idle with a non-empty buffer to first read strobe is 1 cycle.
- out_valid_o is a single-cycle pulse per flit.
- Head bit is not checked. A head+tail flit is a one-flit packet: grant released after it.
- Credit counter:
  - width $clog2(CREDITS+1);
  - read issue and out_credit_i in the same cycle: unchanged;
  - out_credit_i at credits==CREDITS: ignored (saturate);
  - no decrement below 0.
- Requests from non-granted buffers are ignored while locked. in_read_o is never asserted to a non-granted index.
- Reset mid-packet: everything returns to reset values. A partially sent packet is abandoned; credits return to CREDITS.

Optional Feature:
Macro ARB_FLIT_CNT_EN.
- Defined: adds output port flit_cnt_o (32 bits) counting flits forwarded (out_valid_o pulses). Reset to 0, wraps at 2^32.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Package noc_pkg: FLIT_W, HEAD_BIT=15, TAIL_BIT=14, the arb_state_t enum (IDLE, ISSUE, CAPTURE), and a flit_t typedef.
- One sub-module rr_picker: combinational; inputs request vector and rr_ptr, outputs one-hot grant and a found flag. It is reused by the future VC allocator.

Test Plan:
- Reset, then buffer 2 non-empty holding 16'h8000, 16'h0001, 16'h4002 -> grant_o=5'b00100; out_data_o sequence 8000, 0001, 4002, each 2 cycles after its read strobe; then IDLE; rr_ptr=3.
- Buffers 0 and 3 both hold one-flit packets 16'hC0AA and 16'hC0BB, rr_ptr=0 -> 0 is served first, then 3. Repeat with rr_ptr=1 -> 3 first.
- Buffer 1 locked mid-packet while buffer 4 requests -> in_read_o[4] stays 0 until the buffer-1 tail is forwarded.
- No out_credit_i and 9-flit packet -> exactly 8 reads, then stall in ISSUE. One out_credit_i pulse -> 9th flit issued. Credit pulse on the same cycle as a read -> credits unchanged.
- Assert reset during CAPTURE -> next cycle grant_o=0, busy_o=0, out_valid_o=0, credits=8.
- With ARB_FLIT_CNT_EN defined, 3 packets of 4 flits -> flit_cnt_o=12.
